// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_ELEM     = 6;
  localparam int OPS_PER_WORD = 10;

  // Bit [i] of is_write/pol describes op i of the element; pol=1 selects ~BACKGROUND.
  typedef struct packed {
    logic       down;
    logic       two_ops;
    logic [1:0] is_write;
    logic [1:0] pol;
  } elem_t;

  function automatic elem_t march_elem(input logic [2:0] e);
    elem_t m;
    case (e)
      3'd0:    m = '{down: 1'b0, two_ops: 1'b0, is_write: 2'b01, pol: 2'b00}; // up(w0)
      3'd1:    m = '{down: 1'b0, two_ops: 1'b1, is_write: 2'b10, pol: 2'b10}; // up(r0,w1)
      3'd2:    m = '{down: 1'b0, two_ops: 1'b1, is_write: 2'b10, pol: 2'b01}; // up(r1,w0)
      3'd3:    m = '{down: 1'b1, two_ops: 1'b1, is_write: 2'b10, pol: 2'b10}; // dn(r0,w1)
      3'd4:    m = '{down: 1'b1, two_ops: 1'b1, is_write: 2'b10, pol: 2'b01}; // dn(r1,w0)
      default: m = '{down: 1'b0, two_ops: 1'b0, is_write: 2'b00, pol: 2'b00}; // up(r0)
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mbist_resp_checker.sv
// Read-response checker: delays expected data/address to meet mem_rdata, compares,
// captures the first mismatch and counts all of them.
module mbist_resp_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [15:0]           fail_count
);

  logic                  vld_p0, vld_p1;
  logic [DATA_WIDTH-1:0] exp_p0, exp_p1;
  logic [ADDR_WIDTH-1:0] addr_p0, addr_p1;
  logic                  mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= rd_vld;
      vld_p1 <= vld_p0;
    end
  end

  // p0: read on the bus this cycle; p1: the cycle its data returns
  always_ff @(posedge clk) begin
    exp_p0  <= exp_data;
    addr_p0 <= rd_addr;
    exp_p1  <= exp_p0;
    addr_p1 <= addr_p0;
  end

  assign mismatch = vld_p1 && (rdata != exp_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
      fail_count <= '0;
    end else if (clear) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
      fail_count <= '0;
    end else if (mismatch) begin
      if (!fail) begin
        fail_addr <= addr_p1;
        fail_exp  <= exp_p1;
        fail_act  <= rdata;
      end
      fail <= 1'b1;
      if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST initiator: FSM, element/op/address sequencer and memory bus registers.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    CAPACITY   = 16,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [15:0]           fail_count,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);

  state_t                  state, state_next;
  logic                    start_accept;
  logic [2:0]              elem_s;
  logic                    op_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic                    s_done, s_vld;
  logic                    drain_cnt;
  elem_t                   cur, nxt;
  logic                    op_wr, last_in_word, last_addr, last_op;
  logic [DATA_WIDTH-1:0]   op_data;
  logic [ADDR_WIDTH-1:0]   next_start;
  logic                    bus_rd_vld;
  logic [DATA_WIDTH-1:0]   bus_exp;

  always_comb begin
    cur          = march_elem(elem_s);
    nxt          = march_elem(elem_s + 3'd1);
    op_wr        = cur.is_write[op_s];
    op_data      = cur.pol[op_s] ? ~BACKGROUND : BACKGROUND;
    last_in_word = !cur.two_ops || op_s;
    last_addr    = cur.down ? (addr_s == '0) : (addr_s == LAST_ADDR);
    last_op      = last_in_word && last_addr && (elem_s == 3'(NUM_ELEM - 1));
    next_start   = nxt.down ? LAST_ADDR : '0;
    s_vld        = (state == RUN) && !s_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // RUN stays one extra cycle after the sequencer empties so the last op reaches the bus
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_next   = RUN;
        start_accept = 1'b1;
      end
      RUN:     if (s_done) state_next = DRAIN;
      DRAIN:   if (drain_cnt) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_s    <= '0;
      op_s      <= 1'b0;
      addr_s    <= '0;
      s_done    <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      if (start_accept) begin
        elem_s <= '0;
        op_s   <= 1'b0;
        addr_s <= '0;
        s_done <= 1'b0;
      end else if (s_vld) begin
        if (last_op) begin
          s_done <= 1'b1;
        end else if (!last_in_word) begin
          op_s <= 1'b1;
        end else begin
          op_s <= 1'b0;
          if (last_addr) begin
            elem_s <= elem_s + 3'd1;
            addr_s <= next_start;
          end else begin
            addr_s <= cur.down ? addr_s - 1'b1 : addr_s + 1'b1;
          end
        end
      end
      drain_cnt <= (state == DRAIN) && !drain_cnt;
    end
  end

  // Bus stage: command/address one cycle behind the write data driven from stage S
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      bus_rd_vld     <= 1'b0;
    end else begin
      mem_write_read <= s_vld && op_wr;
      mem_address    <= s_vld ? addr_s : '0;
      bus_rd_vld     <= s_vld && !op_wr;
    end
  end

  always_ff @(posedge clk) begin
    bus_exp <= op_data;
  end

  assign mem_wdata = s_vld ? op_data : '0;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  mbist_resp_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_accept),
    .rd_vld    (bus_rd_vld),
    .exp_data  (bus_exp),
    .rd_addr   (mem_address),
    .rdata     (mem_rdata),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_act  (fail_act),
    .fail_count(fail_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl with a 4-word behavioural memory and injectable faults.
module tb_mbist_march_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, fail;
  logic [3:0]  fail_addr;
  logic [7:0]  fail_exp, fail_act;
  logic [15:0] fail_count;
  logic        mem_write_read;
  logic [3:0]  mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int fault_mode = 0;
  bit trace_en = 1'b0;

  mbist_march_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .CAPACITY  (4),
    .BACKGROUND(8'h00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_exp      (fail_exp),
    .fail_act      (fail_act),
    .fail_count    (fail_count),
    .mem_write_read(mem_write_read),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: wdata registered a cycle early, read data returned in the second cycle after the read.
  logic [7:0] mem [16];
  logic [7:0] wd_q = 8'h00;
  logic [7:0] rd_q = 8'h00;

  function automatic logic [7:0] read_word(input logic [3:0] a);
    logic [7:0] v;
    v = (fault_mode == 2 && a == 4'd1) ? mem[2] : mem[a];
    if (fault_mode == 1 && a == 4'd2) v[3] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    wd_q <= mem_wdata;
    if (mem_write_read) mem[mem_address] <= wd_q;
    rd_q      <= read_word(mem_address);
    mem_rdata <= rd_q;
  end

  typedef struct {
    int         cyc;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wd;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic trace_check(input int cyc);
    for (int i = 0; i < 19; i++)
      if (tbl[i].cyc == cyc)
        chk($sformatf("trace_c%0d", cyc), {19'd0, mem_write_read, mem_address, mem_wdata},
            {19'd0, tbl[i].wr, tbl[i].addr, tbl[i].wd});
  endtask

  task automatic start_run(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Returns at the negedge of the cycle in which done is first seen.
  task automatic wait_done(input int exp_cyc, input int pulse_at, input string tag);
    int cyc;
    bit busy_ok;
    bit seen;
    cyc = 0;
    busy_ok = 1'b1;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      if (trace_en) trace_check(cyc);
      if (pulse_at >= 0 && cyc == pulse_at) start = 1'b1;
      else if (pulse_at >= 0 && cyc == pulse_at + 1) start = 1'b0;
      if (done) seen = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_done_edge"}, seen ? cyc : -1, exp_cyc);
    chk({tag, "_busy_during_run"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{0,  1'b0, 4'd0, 8'h00};
    tbl[1]  = '{1,  1'b1, 4'd0, 8'h00};
    tbl[2]  = '{2,  1'b1, 4'd1, 8'h00};
    tbl[3]  = '{3,  1'b1, 4'd2, 8'h00};
    tbl[4]  = '{4,  1'b1, 4'd3, 8'h00};
    tbl[5]  = '{5,  1'b0, 4'd0, 8'hFF};
    tbl[6]  = '{6,  1'b1, 4'd0, 8'h00};
    tbl[7]  = '{12, 1'b1, 4'd3, 8'hFF};
    tbl[8]  = '{13, 1'b0, 4'd0, 8'h00};
    tbl[9]  = '{20, 1'b1, 4'd3, 8'h00};
    tbl[10] = '{21, 1'b0, 4'd3, 8'hFF};
    tbl[11] = '{22, 1'b1, 4'd3, 8'h00};
    tbl[12] = '{23, 1'b0, 4'd2, 8'hFF};
    tbl[13] = '{25, 1'b0, 4'd1, 8'hFF};
    tbl[14] = '{27, 1'b0, 4'd0, 8'hFF};
    tbl[15] = '{28, 1'b1, 4'd0, 8'hFF};
    tbl[16] = '{29, 1'b0, 4'd3, 8'h00};
    tbl[17] = '{40, 1'b0, 4'd3, 8'h00};
    tbl[18] = '{41, 1'b0, 4'd0, 8'h00};
    for (int i = 0; i < 16; i++) mem[i] = 8'h5A;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {29'd0, busy, done, fail}, 32'd0);
    chk("rst_fail_info", {12'd0, fail_addr, fail_exp, fail_act}, 32'd0);
    chk("rst_count", {16'd0, fail_count}, 32'd0);
    chk("rst_bus", {19'd0, mem_write_read, mem_address, mem_wdata}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fault-free run with bus trace
    trace_en = 1'b1;
    start_run(1'b0);
    wait_done(43, -1, "clean");
    trace_en = 1'b0;
    chk("clean_fail", {31'd0, fail}, 32'd0);
    chk("clean_count", {16'd0, fail_count}, 32'd0);

    // Bit 3 of word 2 stuck at 0
    fault_mode = 1;
    start_run(1'b0);
    wait_done(43, -1, "sa0");
    chk("sa0_fail", {31'd0, fail}, 32'd1);
    chk("sa0_addr", {28'd0, fail_addr}, 32'd2);
    chk("sa0_exp", {24'd0, fail_exp}, 32'hFF);
    chk("sa0_act", {24'd0, fail_act}, 32'hF7);
    chk("sa0_count", {16'd0, fail_count}, 32'd2);

    // Word 1 aliases word 2 on read
    fault_mode = 2;
    start_run(1'b0);
    wait_done(43, -1, "adec");
    chk("adec_fail", {31'd0, fail}, 32'd1);
    chk("adec_addr", {28'd0, fail_addr}, 32'd1);
    chk("adec_exp_act", {16'd0, fail_exp, fail_act}, 32'h00FF);
    chk("adec_count", {16'd0, fail_count}, 32'd2);

    // Reset in the middle of element 2, after the first mismatch has been logged
    fault_mode = 1;
    start_run(1'b0);
    repeat (21) @(negedge clk);
    chk("mid_pre_wr", {31'd0, mem_write_read}, 32'd1);
    chk("mid_pre_fail", {31'd0, fail}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {29'd0, busy, done, fail}, 32'd0);
    chk("mid_rst_info", {fail_count, fail_addr, fail_act[3:0], fail_exp}, 32'd0);
    chk("mid_rst_bus", {19'd0, mem_write_read, mem_address, mem_wdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fault_mode = 0;
    start_run(1'b0);
    wait_done(43, 10, "after_rst");
    chk("after_rst_fail", {31'd0, fail}, 32'd0);
    @(negedge clk);
    chk("start_in_run_ignored", {31'd0, done}, 32'd1);

    // start held high through done: immediate second run with cleared results
    fault_mode = 1;
    start_run(1'b1);
    wait_done(43, -1, "hold1");
    chk("hold1_count", {16'd0, fail_count}, 32'd2);
    @(negedge clk);
    chk("hold_restart", {30'd0, busy, done}, 32'd2);
    chk("hold_cleared", {15'd0, fail, fail_count}, 32'd0);
    wait_done(42, -1, "hold2");
    start = 1'b0;
    chk("hold2_count", {16'd0, fail_count}, 32'd2);
    @(negedge clk);
    chk("hold2_stays_done", {30'd0, busy, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
